// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order word requests, buffers responses for the decoder.
// Optional FETCH_ALIGN_CHECK_EN adds fetch_fault for misaligned redirect targets.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BUFFER_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_valid,
  output logic [31:0] instruction_data,
  output logic        instruction_data_valid,
  output logic [31:0] instruction_pc,
  input  logic        instruction_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high at posedge;
  // valid never depends on ready, and payload holds stable while valid && !ready.
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [SW-1:0] in_use;
  logic [31:0]   fifo_data [BUFFER_DEPTH];
  logic [31:0]   fifo_pc   [BUFFER_DEPTH];
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          issue_blocked;
  logic [31:0]   redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign issue_blocked   = fault_q;
  assign fetch_fault     = fault_q;
  assign redirect_target = redirect_pc;
`else
  assign issue_blocked   = 1'b0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Registered occupancy only, so decoder ready never reaches mem_req_valid combinationally.
  assign in_use        = SW'(outstanding) + SW'(count);
  assign mem_req_valid = !rst && !redirect_valid && !issue_blocked &&
                         (in_use < SW'(BUFFER_DEPTH));
  assign mem_addr      = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign instruction_data_valid = (count != '0);
  assign instruction_data       = instruction_data_valid ? fifo_data[head] : 32'h0;
  assign instruction_pc         = instruction_data_valid ? fifo_pc[head] : 32'h0;

  assign push = mem_rsp_valid && (drop == '0);
  assign pop  = instruction_data_valid && instruction_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle's response becomes a drop.
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(mem_rsp_valid);
      drop        <= outstanding - CW'(mem_rsp_valid);
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q     <= (redirect_target[1:0] != 2'b00);
`endif
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
      if (mem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      if (push) begin
        fifo_data[tail] <= mem_rsp_data;
        fifo_pc[tail]   <= resp_pc;
        tail            <= tail + PW'(1);
        resp_pc         <= resp_pc + 32'd4;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, backpressure, redirect/drop,
// random stalls, PC wrap, and misaligned redirect handling.
module tb_instruction_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_valid;
  logic [31:0] instruction_data;
  logic        instruction_data_valid;
  logic [31:0] instruction_pc;
  logic        instruction_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;
  int out_cnt = 0;
  int viol  = 0;

  logic [31:0] req_q[$];
  logic [63:0] out_q[$];
  int          pend_t[$];
  logic [31:0] pend_d[$];

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_valid(mem_rsp_valid),
    .instruction_data(instruction_data),
    .instruction_data_valid(instruction_data_valid),
    .instruction_pc(instruction_pc),
    .instruction_ready(instruction_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0170_0793 : (a ^ 32'h5A5A_0000);
  endfunction

  // In-order memory with programmable latency, plus request/delivery logging.
  always @(posedge clk) begin
    if (rst) begin
      pend_t.delete();
      pend_d.delete();
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= 32'h0;
      out_cnt = 0;
    end else begin
      if (mem_rsp_valid) begin
        if (out_cnt == 0) viol++;
        else out_cnt--;
      end
      if (mem_req_valid && mem_req_ready) begin
        pend_t.push_back(cyc + lat);
        pend_d.push_back(mem_word(mem_addr));
        req_q.push_back(mem_addr);
        out_cnt++;
      end
      if (pend_t.size() > 0 && pend_t[0] <= cyc + 1) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= pend_d[0];
        void'(pend_t.pop_front());
        void'(pend_d.pop_front());
      end else begin
        mem_rsp_valid <= 1'b0;
      end
      if (instruction_data_valid && instruction_ready && !redirect_valid)
        out_q.push_back({instruction_pc, instruction_data});
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mem_req_ready = 1'b0;
    instruction_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) tick();
    rst = 1'b0;
    req_q.delete();
    out_q.delete();
  endtask

  task automatic drain;
    mem_req_ready = 1'b0;
    instruction_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (DEPTH + lat + 4) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    total++; if (instruction_data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid got=%b exp=0", instruction_data_valid); end
    total++; if (instruction_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", instruction_data); end
    total++; if (instruction_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", instruction_pc); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL post_reset_req_valid got=%b exp=1", mem_req_valid); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL post_reset_addr got=%h exp=0", mem_addr); end
    tick();
  endtask

  task automatic test_sequential;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b1;
    @(negedge clk);
    total++; if (instruction_data_valid !== 1'b0) begin bad++; $display("FAIL seq_c0_valid got=%b exp=0", instruction_data_valid); end
    tick();
    tick();
    @(negedge clk);
    total++; if (instruction_data_valid !== 1'b1) begin bad++; $display("FAIL seq_first_valid got=%b exp=1", instruction_data_valid); end
    total++; if (instruction_data !== 32'h0170_0793) begin bad++; $display("FAIL seq_first_data got=%h exp=01700793", instruction_data); end
    total++; if (instruction_pc !== 32'h0) begin bad++; $display("FAIL seq_first_pc got=%h exp=0", instruction_pc); end
    repeat (28) tick();
    drain();
    total++; if (req_q.size() != 30) begin bad++; $display("FAIL seq_req_count got=%0d exp=30", req_q.size()); end
    total++; if (out_q.size() != req_q.size()) begin bad++; $display("FAIL seq_out_count got=%0d exp=%0d", out_q.size(), req_q.size()); end
    for (int i = 0; i < req_q.size(); i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      total++; if (req_q[i] !== a) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, req_q[i], a); end
    end
    for (int i = 0; i < out_q.size(); i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      total++; if (out_q[i] !== {a, mem_word(a)}) begin bad++; $display("FAIL seq_out[%0d] got=%h exp=%h", i, out_q[i], {a, mem_word(a)}); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    total++; if (req_q.size() != DEPTH) begin bad++; $display("FAIL bp_req_count got=%0d exp=%0d", req_q.size(), DEPTH); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_full_req_valid got=%b exp=0", mem_req_valid); end
    total++; if (instruction_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%h exp=0", instruction_pc); end
    total++; if (instruction_data !== 32'h0170_0793) begin bad++; $display("FAIL bp_head_data got=%h exp=01700793", instruction_data); end
    tick();
    instruction_ready = 1'b1;
    repeat (20) tick();
    drain();
    total++; if (out_q.size() != req_q.size()) begin bad++; $display("FAIL bp_out_count got=%0d exp=%0d", out_q.size(), req_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      total++; if (out_q[i] !== {a, mem_word(a)}) begin bad++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, out_q[i], {a, mem_word(a)}); end
    end
  endtask

  task automatic test_redirect;
    do_reset();
    lat = 3;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b0;
    repeat (3) tick();
    mem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle_req_valid got=%b exp=0", mem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b1;
    @(negedge clk);
    total++; if (instruction_data_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_valid got=%b exp=0", instruction_data_valid); end
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL redir_next_req_valid got=%b exp=1", mem_req_valid); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL redir_next_addr got=%h exp=100", mem_addr); end
    repeat (21) tick();
    drain();
    total++; if (req_q.size() < 5) begin bad++; $display("FAIL redir_req_count got=%0d exp>=5", req_q.size()); end
    else begin
      total++; if (req_q[2] !== 32'h8) begin bad++; $display("FAIL redir_req2 got=%h exp=8", req_q[2]); end
      total++; if (req_q[3] !== 32'h100) begin bad++; $display("FAIL redir_req3 got=%h exp=100", req_q[3]); end
    end
    total++; if (out_q.size() < 3) begin bad++; $display("FAIL redir_out_count got=%0d exp>=3", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * i);
      total++; if (out_q[i] !== {a, mem_word(a)}) begin bad++; $display("FAIL redir_out[%0d] got=%h exp=%h", i, out_q[i], {a, mem_word(a)}); end
    end
  endtask

  task automatic test_random_stall;
    int cycles;
    logic prev_hs;
    logic [31:0] prev_addr;
    do_reset();
    lat = 2;
    cycles = 0;
    prev_hs = 1'b1;
    prev_addr = 32'h0;
    while (req_q.size() < 200 && cycles < 3000) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      instruction_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!prev_hs) begin
        total++; if (mem_addr !== prev_addr) begin bad++; $display("FAIL stall_addr_stable got=%h exp=%h", mem_addr, prev_addr); end
      end
      prev_hs = mem_req_valid && mem_req_ready;
      prev_addr = mem_addr;
      tick();
      cycles++;
    end
    total++; if (req_q.size() < 200) begin bad++; $display("FAIL stall_timeout got=%0d exp=200", req_q.size()); end
    drain();
    for (int i = 0; i < req_q.size(); i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      total++; if (req_q[i] !== a) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, req_q[i], a); end
    end
    total++; if (out_q.size() != req_q.size()) begin bad++; $display("FAIL stall_out_count got=%0d exp=%0d", out_q.size(), req_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      total++; if (out_q[i] !== {a, mem_word(a)}) begin bad++; $display("FAIL stall_out[%0d] got=%h exp=%h", i, out_q[i], {a, mem_word(a)}); end
    end
  endtask

  task automatic test_wrap;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    req_q.delete();
    out_q.delete();
    repeat (8) tick();
    drain();
    total++; if (req_q.size() < 3) begin bad++; $display("FAIL wrap_req_count got=%0d exp>=3", req_q.size()); end
    else begin
      total++; if (req_q[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req0 got=%h exp=fffffffc", req_q[0]); end
      total++; if (req_q[1] !== 32'h0) begin bad++; $display("FAIL wrap_req1 got=%h exp=0", req_q[1]); end
      total++; if (req_q[2] !== 32'h4) begin bad++; $display("FAIL wrap_req2 got=%h exp=4", req_q[2]); end
    end
    total++; if (out_q.size() < 2) begin bad++; $display("FAIL wrap_out_count got=%0d exp>=2", out_q.size()); end
    else begin
      total++; if (out_q[0] !== {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}) begin bad++; $display("FAIL wrap_out0 got=%h", out_q[0]); end
      total++; if (out_q[1] !== {32'h0, 32'h0170_0793}) begin bad++; $display("FAIL wrap_out1 got=%h exp=0000000001700793", out_q[1]); end
    end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align_fault;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    req_q.delete();
    out_q.delete();
    @(negedge clk);
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", fetch_fault); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL fault_req_valid got=%b exp=0", mem_req_valid); end
    repeat (6) tick();
    total++; if (req_q.size() != 0) begin bad++; $display("FAIL fault_no_reqs got=%0d exp=0", req_q.size()); end
    total++; if (out_q.size() != 0) begin bad++; $display("FAIL fault_no_out got=%0d exp=0", out_q.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0104;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", fetch_fault); end
    total++; if (mem_addr !== 32'h104) begin bad++; $display("FAIL fault_resume_addr got=%h exp=104", mem_addr); end
    repeat (10) tick();
    drain();
    total++; if (out_q.size() < 1) begin bad++; $display("FAIL fault_resume_count got=%0d exp>=1", out_q.size()); end
    else begin
      total++; if (out_q[0][63:32] !== 32'h104) begin bad++; $display("FAIL fault_resume_pc got=%h exp=104", out_q[0][63:32]); end
    end
  endtask
`else
  task automatic test_unaligned_ignored;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    instruction_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    out_q.delete();
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL unal_req_valid got=%b exp=1", mem_req_valid); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL unal_addr got=%h exp=100", mem_addr); end
    repeat (8) tick();
    drain();
    total++; if (out_q.size() < 1) begin bad++; $display("FAIL unal_out_count got=%0d exp>=1", out_q.size()); end
    else begin
      total++; if (out_q[0] !== {32'h100, mem_word(32'h100)}) begin bad++; $display("FAIL unal_out0 got=%h", out_q[0]); end
    end
  endtask
`endif

  task automatic test_protocol;
    total++; if (viol != 0) begin bad++; $display("FAIL rsp_without_outstanding got=%0d exp=0", viol); end
  endtask

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b0;
    instruction_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_random_stall();
    test_wrap();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align_fault();
`else
    test_unaligned_ignored();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the decoder. It holds the program counter and issues in-order word requests to instruction memory. Returned words are buffered and presented to the decoder on instruction_data / instruction_data_valid with a ready backpressure handshake. A redirect input from the execute stage restarts fetch at a new PC and squashes every in-flight and buffered instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
BUFFER_DEPTH, 2, instruction buffer entries; power of two, >= 2; also the cap on in-flight requests plus buffered entries

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous reset, active-high
mem_addr  output  32  fetch address (word-aligned)
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_rsp_data  input  32  returned instruction word
mem_rsp_valid  input  1  response valid; in order; always accepted
instruction_data  output  32  instruction to decoder
instruction_data_valid  output  1  instruction_data valid
instruction_pc  output  32  PC of instruction_data
instruction_ready  input  1  decoder consumes the head entry
redirect_valid  input  1  restart fetch at redirect_pc
redirect_pc  input  32  new fetch PC

Behaviour:
- Reset, synchronous, active-high on the clk posedge:
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - Buffer count = 0, outstanding = 0, drop = 0.
  - mem_req_valid = 0, instruction_data_valid = 0, instruction_data = 0, instruction_pc = 0.
  - Reset mid-transfer abandons all in-flight responses. The memory is reset by the same rst.
- Issue:
  - mem_req_valid = !redirect_valid && (outstanding + count < BUFFER_DEPTH).
  - mem_addr = fetch_pc.
  - Handshake is mem_req_valid && mem_req_ready. On handshake: fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0), and outstanding += 1.
  - While stalled on !mem_req_ready, mem_addr stays stable.
  - The outstanding + count check counts handshakes and pops from the previous cycle only, so no combinational path runs from instruction_ready to mem_req_valid.
- Response, when mem_rsp_valid:
  - outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise push {resp_pc, mem_rsp_data} into the buffer and set resp_pc += 4.
  - The issue rule guarantees the buffer never overflows. A response with outstanding == 0 is illegal; the bench asserts it never occurs.
- Output:
  - instruction_data_valid = (count != 0); instruction_data and instruction_pc come from the buffer head.
  - Pop on instruction_data_valid && instruction_ready.
  - Push and pop in the same cycle with count in 1..DEPTH-1 leave count unchanged.
  - Latency: a response at posedge N makes the word valid at the decoder after posedge N+1. There is no bypass.
  - Head outputs hold stable while valid && !ready.
- Redirect (priority over everything except rst), in the cycle redirect_valid = 1:
  - No request is issued.
  - Buffer is flushed; any pop or push that cycle is ignored.
  - A response arriving that cycle is discarded.
  - fetch_pc = resp_pc = redirect_pc.
  - drop = outstanding after this cycle's response accounting. Drops still pending from an earlier redirect are therefore included.
  - Back-to-back redirects: the last one wins.
  - First request appears the cycle after the redirect.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault = 1 on the next cycle.
  - While fetch_fault = 1, mem_req_valid is held 0; flush and drop accounting still happen.
  - The next redirect with an aligned redirect_pc clears fetch_fault and resumes fetch.
- When undefined:
  - No fetch_fault port.
  - redirect_pc[1:0] is ignored and forced to 0 for fetch_pc and resp_pc.

Test Plan:
- Reset, then ready held 1 and a 1-cycle-latency memory with mem[0] = 32'h0170_0793 (addi x15,x0,23) -> mem_addr 0,4,8,... and first valid output is instruction_data 32'h0170_0793 with instruction_pc 0, followed by contiguous PCs at full throughput.
- instruction_ready held 0 for 10 cycles -> at most BUFFER_DEPTH requests issued and mem_req_valid = 0 once full. Releasing ready drains the buffer in order with no loss or duplication.
- Redirect to 32'h0000_0100 while 2 requests are outstanding and 1 entry is buffered -> instruction_data_valid = 0 next cycle, both late responses discarded, first delivered instruction_pc = 32'h100.
- mem_req_ready toggled randomly over 200 requests -> mem_addr stable during every stall and the PC sequence has no gaps.
- Redirect to 32'hFFFF_FFFC -> requests to FFFF_FFFC, then 0000_0000, then 0000_0004.
- With FETCH_ALIGN_CHECK_EN, redirect to 32'h102 -> fetch_fault = 1 and no requests. Then redirect to 32'h104 -> fetch_fault = 0 and the first delivered instruction_pc = 32'h104.
